// File: rtl/seq_mul_add_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_add_pkg
//   Shared definitions for the sequential multiply-accumulate block:
//   default operand width and the FSM state encoding.  The encoding matches
//   the restoring divider so both blocks decode state the same way.
// ---------------------------------------------------------------------------
package seq_mul_add_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_add.sv
// ---------------------------------------------------------------------------
// seq_mul_add
//   Sequential shift-add multiply-accumulate, unsigned: p = q*b + r.
//   Used as the inverse of the restoring divider (quotient, divisor,
//   remainder in -> dividend out) and as a general small multiplier.
//   Fixed latency of W CALC cycles, one operation in flight.
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    q/b/r valid
//   in_ready   out  1    operands accepted (IDLE only)
//   q          in   W    multiplier (quotient)
//   b          in   W    multiplicand (divisor)
//   r          in   W    addend (remainder), zero-extended
//   out_valid  out  1    p valid, held until out_ready
//   out_ready  in   1    downstream accepts p
//   p          out  2W   result q*b + r
// ---------------------------------------------------------------------------
module seq_mul_add
  import seq_mul_add_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = $clog2(W) + 1;

  state_t           state_r;
  state_t           state_next_s;
  logic [2*W-1:0]   acc_r;
  logic [2*W-1:0]   mcand_r;
  logic [W-1:0]     mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [2*W-1:0]   p_r;
  logic             out_valid_r;
  logic [2*W-1:0]   acc_step_s;
  logic             last_step_s;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set.  q*b + r never exceeds 2^(2W) - 2^W, so the
  // 2W-bit sum cannot overflow and no carry out is kept.
  function automatic logic [2*W-1:0] mac_step(input logic [2*W-1:0] acc,
                                              input logic [2*W-1:0] mcand,
                                              input logic           bit0);
    if (bit0) begin
      return acc + mcand;
    end else begin
      return acc;
    end
  endfunction

  assign acc_step_s  = mac_step(acc_r, mcand_r, mplier_r[0]);
  assign last_step_s = (cnt_r == CW'(W - 1));

  // in_ready depends on state only, never on in_valid.
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = out_valid_r;
  assign p         = p_r;

  // Next-state logic; unused encoding falls back to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_CALC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        // No early exit on a zero multiplier: latency is data-independent.
        if (last_step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand capture, shift-add iteration, result and valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= {(2*W){1'b0}};
      mcand_r     <= {(2*W){1'b0}};
      mplier_r    <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      p_r         <= {(2*W){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            acc_r    <= {{W{1'b0}}, r};
            mcand_r  <= {{W{1'b0}}, b};
            mplier_r <= q;
            cnt_r    <= {CW{1'b0}};
          end
        end
        ST_CALC: begin
          acc_r    <= acc_step_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (last_step_s) begin
            p_r         <= acc_step_s;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          // p_r keeps the last result after the handshake.
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_add.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_add
//   Self-checking bench for seq_mul_add.  The driver pushes the expected
//   result into a queue when it issues an operation; a separate monitor pops
//   and compares whenever a result is handed off (out_valid && out_ready).
// ---------------------------------------------------------------------------
module tb_seq_mul_add;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  b;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;

  int          pass_cnt;
  int          total_cnt;
  logic [15:0] exp_q[$];

  seq_mul_add #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .b         (b),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every handed-off result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(p), 32'hFFFF_FFFF);
      end else begin
        check("result", 32'(p), 32'(exp_q.pop_front()));
      end
    end
  end

  // Wait for in_ready, present operands for one accept edge, then scramble
  // them so any late sampling would corrupt the result.
  task automatic issue(input logic [7:0] qv, input logic [7:0] bv, input logic [7:0] rv,
                       input logic [15:0] exp, input bit track);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    q = qv; b = bv; r = rv;
    in_valid = 1'b1;
    if (track) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    int seen_valid;
    int guard;
    logic [7:0] bl [10];
    pass_cnt = 0; total_cnt = 0;
    bl = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd100, 8'd128, 8'd200, 8'd254, 8'd255};

    // 1: reset asserted from t=0 with clocks running
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    q = 8'd0; b = 8'd0; r = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2: 13*7+5 = 96, latency 9 edges including the accept edge
    issue(8'd13, 8'd7, 8'd5, 16'd96, 1'b1);
    check("calc_in_ready", 32'(in_ready), 32'd0);
    wait_valid(edges);
    check("latency", 32'(edges + 1), 32'd9);
    @(posedge clk); #1;
    check("post_handshake_in_ready", 32'(in_ready), 32'd1);
    check("post_handshake_out_valid", 32'(out_valid), 32'd0);
    check("p_held_in_idle", 32'(p), 32'd96);

    // 3: boundary operands
    issue(8'd255, 8'd255, 8'd255, 16'd65280, 1'b1);
    wait_valid(edges);
    check("latency_max_operands", 32'(edges + 1), 32'd9);
    issue(8'd0, 8'd200, 8'd9, 16'd9, 1'b1);
    wait_valid(edges);
    check("latency_q_zero", 32'(edges + 1), 32'd9);
    issue(8'd200, 8'd0, 8'd0, 16'd0, 1'b1);
    wait_valid(edges);

    // 4: backpressure for 20 cycles with a competing in_valid
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(8'd13, 8'd7, 8'd5, 16'd96, 1'b1);
    wait_valid(edges);
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    q = 8'd1; b = 8'd1; r = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_p_held", 32'(p), 32'd96);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    issue(8'd3, 8'd5, 8'd2, 16'd17, 1'b1);
    wait_valid(edges);
    check("bp_next_latency", 32'(edges + 1), 32'd9);
    @(posedge clk); #1;

    // 5: reset at CALC cycle 4 aborts the operation
    issue(8'd13, 8'd7, 8'd5, 16'd96, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1;
    end
    check("abort_no_out_valid", 32'(seen_valid), 32'd0);
    issue(8'd3, 8'd3, 8'd1, 16'd10, 1'b1);
    wait_valid(edges);
    check("after_abort_latency", 32'(edges + 1), 32'd9);

    // 6: round-trip with divider results, a = (a/b)*b + a%b
    for (int a = 0; a < 256; a += 17) begin
      for (int k = 0; k < 10; k++) begin
        issue(8'(a / int'(bl[k])), bl[k], 8'(a % int'(bl[k])), 16'(a), 1'b1);
      end
    end
    for (int k = 0; k < 60; k++) begin
      int av = int'($urandom_range(255, 0));
      int bv = int'($urandom_range(255, 1));
      issue(8'(av / bv), 8'(bv), 8'(av % bv), 16'(av), 1'b1);
    end

    // drain the scoreboard
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
